// File: rtl/legv8_pkg.sv
// Shared encodings for the LEGv8 control path: sequencer states, opcode
// match patterns, ALU operation codes and the opcode class type.
package legv8_pkg;

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_EX_R    = 4'd2;
   localparam logic [3:0] S_WB_R    = 4'd3;
   localparam logic [3:0] S_EX_ADDR = 4'd4;
   localparam logic [3:0] S_MEM_RD  = 4'd5;
   localparam logic [3:0] S_WB_LD   = 4'd6;
   localparam logic [3:0] S_MEM_WR  = 4'd7;
   localparam logic [3:0] S_EX_BR   = 4'd8;
   localparam logic [3:0] S_TRAP    = 4'd9;

   // '?' bits are don't-care in the casez match
   localparam logic [10:0] OP_R    = 11'b1??0101?000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100???;
   localparam logic [10:0] OP_NOP  = 11'b00000000000;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_PASSB = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef enum logic [2:0] {
      CLS_NOP = 3'd0,
      CLS_R   = 3'd1,
      CLS_LD  = 3'd2,
      CLS_ST  = 3'd3,
      CLS_CB  = 3'd4,
      CLS_ILL = 3'd5
   } op_class_t;

   function automatic logic is_mem_state(input logic [3:0] st);
      return (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
   endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier, shared between the single-cycle and
// multi-cycle control paths.
module opcode_class_decode
   import legv8_pkg::*;
(
   input  logic [10:0] operation,
   output op_class_t   op_class
);

   // Map the 11-bit opcode field to its instruction class
   always_comb begin
      op_class = CLS_ILL;
      casez (operation)
         OP_NOP:  op_class = CLS_NOP;
         OP_LDUR: op_class = CLS_LD;
         OP_STUR: op_class = CLS_ST;
         OP_CBZ:  op_class = CLS_CB;
         OP_R:    op_class = CLS_R;
         default: op_class = CLS_ILL;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 sequencer: FETCH/DECODE/EXEC/MEM/WB with a mem_ready
// handshake, a per-access wait timeout and a sticky trap on illegal opcodes.
module multicycle_control
   import legv8_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int TO_W        = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [10:0] Operation,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       Reg2Loc,
   output logic       ALUSrc,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic [1:0] ALUOperation,
   output logic       PCWrite,
   output logic       PCSrc,
   output logic       IRWrite,
   output logic       retire,
   output logic       fault,
   output logic [3:0] state_o
);

   logic [3:0]      state_r;
   logic [3:0]      next_state_s;
   op_class_t       class_s;
   op_class_t       class_r;
   logic [TO_W-1:0] wait_r;
   logic            fault_r;
   logic            mem_state_s;
   logic            timeout_s;

   opcode_class_decode u_decode (
      .operation (Operation),
      .op_class  (class_s)
   );

   assign mem_state_s = is_mem_state(state_r);
   // mem_ready in the timeout cycle wins, so the timeout requires it low
   assign timeout_s   = (MEM_TIMEOUT != 0) && mem_state_s && !mem_ready &&
                        (wait_r == TO_W'(MEM_TIMEOUT));
   assign state_o     = state_r;
   assign fault       = fault_r;

   // Next-state selection
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         S_FETCH: begin
            if (timeout_s)      next_state_s = S_TRAP;
            else if (mem_ready) next_state_s = S_DECODE;
            else                next_state_s = S_FETCH;
         end
         S_DECODE: begin
            case (class_s)
               CLS_R:          next_state_s = S_EX_R;
               CLS_LD, CLS_ST: next_state_s = S_EX_ADDR;
               CLS_CB:         next_state_s = S_EX_BR;
               CLS_NOP:        next_state_s = S_FETCH;
               default:        next_state_s = S_TRAP;
            endcase
         end
         S_EX_R:  next_state_s = S_WB_R;
         S_WB_R:  next_state_s = S_FETCH;
         S_EX_ADDR: begin
            if (class_r == CLS_LD)      next_state_s = S_MEM_RD;
            else if (class_r == CLS_ST) next_state_s = S_MEM_WR;
            else                        next_state_s = S_TRAP;
         end
         S_MEM_RD: begin
            if (timeout_s)      next_state_s = S_TRAP;
            else if (mem_ready) next_state_s = S_WB_LD;
            else                next_state_s = S_MEM_RD;
         end
         S_WB_LD: next_state_s = S_FETCH;
         S_MEM_WR: begin
            if (timeout_s)      next_state_s = S_TRAP;
            else if (mem_ready) next_state_s = S_FETCH;
            else                next_state_s = S_MEM_WR;
         end
         S_EX_BR: next_state_s = S_FETCH;
         S_TRAP:  next_state_s = S_TRAP;
         default: next_state_s = S_TRAP;
      endcase
   end

   // State, latched class, wait counter and sticky fault
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= S_FETCH;
         class_r <= CLS_NOP;
         wait_r  <= {TO_W{1'b0}};
         fault_r <= 1'b0;
      end else begin
         state_r <= next_state_s;
         if (state_r == S_DECODE) begin
            class_r <= class_s;
         end
         // Count only while parked in a memory state; any exit clears it
         if (mem_state_s && !mem_ready && (next_state_s == state_r)) begin
            wait_r <= wait_r + TO_W'(1);
         end else begin
            wait_r <= {TO_W{1'b0}};
         end
         if (next_state_s == S_TRAP) begin
            fault_r <= 1'b1;
         end
      end
   end

   // Per-state datapath strobes, forced low while reset is held
   always_comb begin
      Reg2Loc      = 1'b0;
      ALUSrc       = 1'b0;
      MemtoReg     = 1'b0;
      RegWrite     = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      ALUOperation = ALU_ADD;
      PCWrite      = 1'b0;
      PCSrc        = 1'b0;
      IRWrite      = 1'b0;
      retire       = 1'b0;
      if (rst_n) begin
         case (state_r)
            S_FETCH: begin
               MemRead = 1'b1;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
            end
            S_DECODE: begin
               Reg2Loc = (class_s == CLS_ST) || (class_s == CLS_CB);
               retire  = (class_s == CLS_NOP);
            end
            S_EX_R: ALUOperation = ALU_FUNCT;
            S_WB_R: begin
               ALUOperation = ALU_FUNCT;
               RegWrite     = 1'b1;
               retire       = 1'b1;
            end
            S_EX_ADDR: ALUSrc = 1'b1;
            S_MEM_RD: begin
               ALUSrc  = 1'b1;
               MemRead = 1'b1;
            end
            S_WB_LD: begin
               MemtoReg = 1'b1;
               RegWrite = 1'b1;
               retire   = 1'b1;
            end
            S_MEM_WR: begin
               Reg2Loc  = 1'b1;
               ALUSrc   = 1'b1;
               MemWrite = 1'b1;
               retire   = mem_ready;
            end
            S_EX_BR: begin
               Reg2Loc      = 1'b1;
               ALUOperation = ALU_PASSB;
               PCSrc        = 1'b1;
               PCWrite      = Zero;
               retire       = 1'b1;
            end
            default: begin
               Reg2Loc = 1'b0;
            end
         endcase
      end else begin
         retire = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each cycle pushes the expected
// state/strobe vector to a scoreboard queue and checks it against the DUT.
module tb_multicycle_control;
   import legv8_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [10:0] Operation;
   logic       Zero;
   logic       mem_ready;
   logic       Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
   logic [1:0] ALUOperation;
   logic       PCWrite, PCSrc, IRWrite, retire, fault;
   logic [3:0] state_o;

   int n_cmp = 0;
   int n_err = 0;
   logic [16:0] exp_q[$];
   string       tag_q[$];

   localparam logic [10:0] I_ADD  = 11'b10001011000;
   localparam logic [10:0] I_LDUR = 11'b11111000010;
   localparam logic [10:0] I_STUR = 11'b11111000000;
   localparam logic [10:0] I_CBZ  = 11'b10110100101;
   localparam logic [10:0] I_ILL  = 11'b11111111111;
   localparam logic [10:0] I_NOP  = 11'b00000000000;

   // {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp[1:0], PCWrite, PCSrc, IRWrite, retire, fault}
   localparam logic [12:0] B_R2L   = 13'h1000;
   localparam logic [12:0] B_AS    = 13'h0800;
   localparam logic [12:0] B_M2R   = 13'h0400;
   localparam logic [12:0] B_RW    = 13'h0200;
   localparam logic [12:0] B_MR    = 13'h0100;
   localparam logic [12:0] B_MW    = 13'h0080;
   localparam logic [12:0] B_FUNCT = 13'h0040;
   localparam logic [12:0] B_PASSB = 13'h0020;
   localparam logic [12:0] B_PCW   = 13'h0010;
   localparam logic [12:0] B_PCS   = 13'h0008;
   localparam logic [12:0] B_IRW   = 13'h0004;
   localparam logic [12:0] B_RET   = 13'h0002;
   localparam logic [12:0] B_FLT   = 13'h0001;
   localparam logic [12:0] B_NONE  = 13'h0000;
   localparam logic [12:0] F_HIT   = 13'h0114;   // MemRead | PCWrite | IRWrite

   multicycle_control #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Operation    (Operation),
      .Zero         (Zero),
      .mem_ready    (mem_ready),
      .Reg2Loc      (Reg2Loc),
      .ALUSrc       (ALUSrc),
      .MemtoReg     (MemtoReg),
      .RegWrite     (RegWrite),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .ALUOperation (ALUOperation),
      .PCWrite      (PCWrite),
      .PCSrc        (PCSrc),
      .IRWrite      (IRWrite),
      .retire       (retire),
      .fault        (fault),
      .state_o      (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle (called at negedge), then check the expected vector
   task automatic cyc(input logic rn, input logic mr, input logic z, input logic [10:0] op,
                      input logic [3:0] st, input logic [12:0] sb, input string tag);
      logic [16:0] got;
      logic [16:0] exp_v;
      string       t;
      rst_n = rn; mem_ready = mr; Zero = z; Operation = op;
      exp_q.push_back({st, sb});
      tag_q.push_back(tag);
      #1;
      got   = {state_o, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
               ALUOperation, PCWrite, PCSrc, IRWrite, retire, fault};
      exp_v = exp_q.pop_front();
      t     = tag_q.pop_front();
      n_cmp++;
      assert (got === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", t, got, exp_v);
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic rn, input logic mr, input logic [10:0] op);
      rst_n = rn; mem_ready = mr; Zero = 1'b0; Operation = op;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; mem_ready = 1'b0; Zero = 1'b0; Operation = I_NOP;
      @(negedge clk);
      drive(1'b0, 1'b0, I_NOP);
      cyc(1'b0, 1'b1, 1'b0, I_NOP, S_FETCH, B_NONE, "reset_gated");

      // ADD with immediate memory
      cyc(1'b1, 1'b1, 1'b0, I_ADD, S_FETCH,  F_HIT,                 "add_fetch");
      cyc(1'b1, 1'b1, 1'b0, I_ADD, S_DECODE, B_NONE,                "add_decode");
      cyc(1'b1, 1'b1, 1'b0, I_ADD, S_EX_R,   B_FUNCT,               "add_ex");
      cyc(1'b1, 1'b1, 1'b0, I_ADD, S_WB_R,   B_FUNCT | B_RW | B_RET, "add_wb");

      // LDUR with three wait cycles; Operation garbage after decode
      cyc(1'b1, 1'b1, 1'b0, I_LDUR, S_FETCH,   F_HIT,  "ld_fetch");
      cyc(1'b1, 1'b1, 1'b0, I_LDUR, S_DECODE,  B_NONE, "ld_decode");
      cyc(1'b1, 1'b1, 1'b0, I_ILL,  S_EX_ADDR, B_AS,   "ld_addr");
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 1'b0, 1'b0, I_ILL, S_MEM_RD, B_AS | B_MR, "ld_wait");
      cyc(1'b1, 1'b1, 1'b0, I_ILL, S_MEM_RD, B_AS | B_MR,           "ld_mem");
      cyc(1'b1, 1'b1, 1'b0, I_ILL, S_WB_LD,  B_M2R | B_RW | B_RET,  "ld_wb");

      // CBZ taken then not taken
      cyc(1'b1, 1'b1, 1'b1, I_CBZ, S_FETCH,  F_HIT, "cb1_fetch");
      cyc(1'b1, 1'b1, 1'b1, I_CBZ, S_DECODE, B_R2L, "cb1_decode");
      cyc(1'b1, 1'b1, 1'b1, I_CBZ, S_EX_BR,  B_R2L | B_PASSB | B_PCS | B_PCW | B_RET, "cb1_br");
      cyc(1'b1, 1'b1, 1'b0, I_CBZ, S_FETCH,  F_HIT, "cb0_fetch");
      cyc(1'b1, 1'b1, 1'b0, I_CBZ, S_DECODE, B_R2L, "cb0_decode");
      cyc(1'b1, 1'b1, 1'b0, I_CBZ, S_EX_BR,  B_R2L | B_PASSB | B_PCS | B_RET, "cb0_br");

      // NOP retires from decode
      cyc(1'b1, 1'b1, 1'b0, I_NOP, S_FETCH,  F_HIT, "nop_fetch");
      cyc(1'b1, 1'b1, 1'b0, I_NOP, S_DECODE, B_RET, "nop_decode");

      // STUR completing immediately
      cyc(1'b1, 1'b1, 1'b0, I_STUR, S_FETCH,   F_HIT, "st_fetch");
      cyc(1'b1, 1'b1, 1'b0, I_STUR, S_DECODE,  B_R2L, "st_decode");
      cyc(1'b1, 1'b1, 1'b0, I_STUR, S_EX_ADDR, B_AS,  "st_addr");
      cyc(1'b1, 1'b1, 1'b0, I_STUR, S_MEM_WR,  B_R2L | B_AS | B_MW | B_RET, "st_mem");

      // Reset during a pending store, then a clean ADD
      cyc(1'b1, 1'b1, 1'b0, I_STUR, S_FETCH,   F_HIT, "rs_fetch");
      cyc(1'b1, 1'b1, 1'b0, I_STUR, S_DECODE,  B_R2L, "rs_decode");
      cyc(1'b1, 1'b0, 1'b0, I_STUR, S_EX_ADDR, B_AS,  "rs_addr");
      cyc(1'b1, 1'b0, 1'b0, I_STUR, S_MEM_WR,  B_R2L | B_AS | B_MW, "rs_wait");
      cyc(1'b0, 1'b0, 1'b0, I_STUR, S_MEM_WR,  B_NONE, "rs_abandon");
      cyc(1'b1, 1'b1, 1'b0, I_ADD,  S_FETCH,   F_HIT,  "rs_add_fetch");
      cyc(1'b1, 1'b1, 1'b0, I_ADD,  S_DECODE,  B_NONE, "rs_add_decode");
      cyc(1'b1, 1'b1, 1'b0, I_ADD,  S_EX_R,    B_FUNCT, "rs_add_ex");
      cyc(1'b1, 1'b1, 1'b0, I_ADD,  S_WB_R,    B_FUNCT | B_RW | B_RET, "rs_add_wb");

      // STUR timeout: five MemWrite cycles, no retire, then trap
      cyc(1'b1, 1'b1, 1'b0, I_STUR, S_FETCH,   F_HIT, "to_fetch");
      cyc(1'b1, 1'b1, 1'b0, I_STUR, S_DECODE,  B_R2L, "to_decode");
      cyc(1'b1, 1'b0, 1'b0, I_STUR, S_EX_ADDR, B_AS,  "to_addr");
      for (int i = 0; i < 5; i++)
         cyc(1'b1, 1'b0, 1'b0, I_STUR, S_MEM_WR, B_R2L | B_AS | B_MW, "to_wait");
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 1'b0, 1'b0, I_STUR, S_TRAP, B_FLT, "to_trap");
      drive(1'b0, 1'b0, I_STUR);

      // STUR with mem_ready on the fifth wait cycle completes normally
      cyc(1'b1, 1'b1, 1'b0, I_STUR, S_FETCH,   F_HIT, "late_fetch");
      cyc(1'b1, 1'b1, 1'b0, I_STUR, S_DECODE,  B_R2L, "late_decode");
      cyc(1'b1, 1'b0, 1'b0, I_STUR, S_EX_ADDR, B_AS,  "late_addr");
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 1'b0, 1'b0, I_STUR, S_MEM_WR, B_R2L | B_AS | B_MW, "late_wait");
      cyc(1'b1, 1'b1, 1'b0, I_STUR, S_MEM_WR,  B_R2L | B_AS | B_MW | B_RET, "late_done");
      cyc(1'b1, 1'b0, 1'b0, I_NOP,  S_FETCH,   B_MR,  "late_nofault");

      // Illegal opcode traps and stays trapped regardless of inputs
      cyc(1'b1, 1'b1, 1'b0, I_ILL, S_FETCH,  F_HIT,  "ill_fetch");
      cyc(1'b1, 1'b1, 1'b0, I_ILL, S_DECODE, B_NONE, "ill_decode");
      for (int i = 0; i < 20; i++)
         cyc(1'b1, i[0], i[1], (i[2] ? I_ADD : I_ILL), S_TRAP, B_FLT, "ill_trap");
      drive(1'b0, 1'b1, I_NOP);
      cyc(1'b1, 1'b0, 1'b0, I_NOP, S_FETCH, B_MR, "ill_recover");

      // Fetch timeout: four more waits, the fifth cycle times out
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 1'b0, 1'b0, I_NOP, S_FETCH, B_MR, "fto_wait");
      cyc(1'b1, 1'b0, 1'b0, I_NOP, S_TRAP, B_FLT, "fto_trap");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
